// File: rtl/ep_dbi_req_ctrl.sv
// ep_dbi_req_ctrl: upstream front end for the external DBI port.
// Takes one register read/write command at a time, runs the DBI cs/ack
// handshake with a timeout, and returns read data plus an error flag.
//
// Handshakes: a request is taken on a rising core_clk edge where
// req_valid & req_ready, and a response is retired on an edge where
// rsp_valid & rsp_ready. Once valid is raised, the payload stays stable
// until that handshake edge. Only one command is outstanding at a time.
`timescale 1ns/1ps
module ep_dbi_req_ctrl #(
   parameter int unsigned TIMEOUT = 200,  // max cs-high cycles per access (2..255)
   parameter int unsigned GAP_CYC = 2     // cs-low cycles after each access (1..15)
) (
   input  logic        core_clk,
   input  logic        pcie_rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   input  logic        req_cs2,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] dbi_din,
   output logic [3:0]  dbi_wr,
   output logic [31:0] dbi_addr,
   output logic        dbi_cs,
   output logic        dbi_cs2_exp,
   input  logic        dbi_ack,
   input  logic [31:0] dbi_dout,
   output logic [7:0]  err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

   // state is the FSM state for checkers and debug probes
   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;          // cs-high cycles of the current access
   logic [3:0]  gap_cnt, gap_cnt_nxt;  // cs-low cycles spent in GAP
   logic        cmd_wr, cmd_wr_nxt;    // latched direction of the command

   logic        req_ready_nxt;
   logic        rsp_valid_nxt;
   logic [31:0] rsp_rdata_nxt;
   logic        rsp_err_nxt;
   logic [31:0] dbi_din_nxt;
   logic [3:0]  dbi_wr_nxt;
   logic [31:0] dbi_addr_nxt;
   logic        dbi_cs_nxt;
   logic        dbi_cs2_exp_nxt;
   logic [7:0]  err_cnt_nxt;

   // State and every output are registered; reset drops dbi_cs at once
   always_ff @(posedge core_clk or negedge pcie_rst_n) begin
      if (!pcie_rst_n) begin
         state       <= ST_IDLE;
         cnt         <= 8'd0;
         gap_cnt     <= 4'd0;
         cmd_wr      <= 1'b0;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 32'd0;
         rsp_err     <= 1'b0;
         dbi_din     <= 32'd0;
         dbi_wr      <= 4'd0;
         dbi_addr    <= 32'd0;
         dbi_cs      <= 1'b0;
         dbi_cs2_exp <= 1'b0;
         err_cnt     <= 8'd0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         gap_cnt     <= gap_cnt_nxt;
         cmd_wr      <= cmd_wr_nxt;
         req_ready   <= req_ready_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         rsp_err     <= rsp_err_nxt;
         dbi_din     <= dbi_din_nxt;
         dbi_wr      <= dbi_wr_nxt;
         dbi_addr    <= dbi_addr_nxt;
         dbi_cs      <= dbi_cs_nxt;
         dbi_cs2_exp <= dbi_cs2_exp_nxt;
         err_cnt     <= err_cnt_nxt;
      end
   end

   // Next state and next register values; everything holds unless changed
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      gap_cnt_nxt     = gap_cnt;
      cmd_wr_nxt      = cmd_wr;
      req_ready_nxt   = req_ready;
      rsp_valid_nxt   = rsp_valid;
      rsp_rdata_nxt   = rsp_rdata;
      rsp_err_nxt     = rsp_err;
      dbi_din_nxt     = dbi_din;
      dbi_wr_nxt      = dbi_wr;
      dbi_addr_nxt    = dbi_addr;
      dbi_cs_nxt      = dbi_cs;
      dbi_cs2_exp_nxt = dbi_cs2_exp;
      err_cnt_nxt     = err_cnt;

      unique case (state)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               cmd_wr_nxt      = req_wr;
               dbi_addr_nxt    = req_addr;
               dbi_din_nxt     = req_wdata;
               dbi_cs2_exp_nxt = req_cs2;
               dbi_wr_nxt      = req_wr ? req_be : 4'h0;
               req_ready_nxt   = 1'b0;
               if (req_wr && (req_be == 4'h0)) begin
                  // empty write: nothing to put on the bus, answer at once
                  state_nxt     = ST_RESP;
                  rsp_valid_nxt = 1'b1;
                  rsp_rdata_nxt = 32'd0;
                  rsp_err_nxt   = 1'b0;
               end else begin
                  state_nxt  = ST_ISSUE;
                  dbi_cs_nxt = 1'b1;
                  cnt_nxt    = 8'd0;
               end
            end
         end

         ST_ISSUE: begin
            if (dbi_ack) begin
               // ack beats a timeout landing in the same cycle
               state_nxt     = ST_GAP;
               dbi_cs_nxt    = 1'b0;
               gap_cnt_nxt   = 4'd0;
               rsp_rdata_nxt = cmd_wr ? 32'd0 : dbi_dout;
               rsp_err_nxt   = 1'b0;
            end else if (cnt == CNT_LAST) begin
               state_nxt     = ST_GAP;
               dbi_cs_nxt    = 1'b0;
               gap_cnt_nxt   = 4'd0;
               rsp_rdata_nxt = 32'd0;
               rsp_err_nxt   = 1'b1;
               if (err_cnt != 8'hFF) begin
                  err_cnt_nxt = err_cnt + 8'd1;
               end
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end

         ST_GAP: begin
            // late acks from the target are dropped here
            if (gap_cnt == GAP_LAST) begin
               state_nxt     = ST_RESP;
               rsp_valid_nxt = 1'b1;
            end else begin
               gap_cnt_nxt = gap_cnt + 4'd1;
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt     = ST_IDLE;
               rsp_valid_nxt = 1'b0;
               req_ready_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ep_dbi_req_ctrl.sv
// tb_ep_dbi_req_ctrl: directed bench for ep_dbi_req_ctrl with
// hand-computed expectations and an expected-response queue.
`timescale 1ns/1ps
module tb_ep_dbi_req_ctrl;

   localparam int TIMEOUT = 200;
   localparam int GAP_CYC = 2;

   logic        core_clk;
   logic        pcie_rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        req_cs2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] dbi_din;
   logic [3:0]  dbi_wr;
   logic [31:0] dbi_addr;
   logic        dbi_cs;
   logic        dbi_cs2_exp;
   logic        dbi_ack;
   logic [31:0] dbi_dout;
   logic [7:0]  err_cnt;

   int n_checks;
   int n_fails;
   logic [31:0] exp_q[$];

   ep_dbi_req_ctrl #(
      .TIMEOUT (TIMEOUT),
      .GAP_CYC (GAP_CYC)
   ) dut (
      .core_clk    (core_clk),
      .pcie_rst_n  (pcie_rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_be      (req_be),
      .req_cs2     (req_cs2),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .dbi_din     (dbi_din),
      .dbi_wr      (dbi_wr),
      .dbi_addr    (dbi_addr),
      .dbi_cs      (dbi_cs),
      .dbi_cs2_exp (dbi_cs2_exp),
      .dbi_ack     (dbi_ack),
      .dbi_dout    (dbi_dout),
      .err_cnt     (err_cnt)
   );

   // clock / reset
   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   // driver: present one command and hold it until it is accepted
   task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic cs2);
      int w;
      w         = 0;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_cs2   = cs2;
      while (req_ready !== 1'b1 && w < 50) begin
         w++;
         tick();
      end
      chk("send_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   // DBI target model: ack in the cs-high cycle numbered ack_at (0-based),
   // never if ack_at < 0; returns cs-high length and cs-fall-to-rsp latency
   task automatic run_access(input int ack_at, input logic [31:0] dout,
                             output int cs_cycles, output int lat);
      cs_cycles = 0;
      while (dbi_cs === 1'b1 && cs_cycles < 1000) begin
         dbi_ack  = (cs_cycles == ack_at);
         dbi_dout = (cs_cycles == ack_at) ? dout : 32'hFFFF_FFFF;
         cs_cycles++;
         tick();
      end
      dbi_ack  = 1'b0;
      dbi_dout = 32'hA5A5_A5A5;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 100) begin
         lat++;
         tick();
      end
   endtask

   // scoreboard: compare the presented response, then retire it
   task automatic take_rsp(input string tag, input logic exp_err, input logic [7:0] exp_cnt);
      logic [31:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
      chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_rdata"}, rsp_rdata, e);
      chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      chk({tag, "_errcnt"}, {24'd0, err_cnt}, {24'd0, exp_cnt});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int cs_n;
      int lat;
      int bad;
      n_checks   = 0;
      n_fails    = 0;
      pcie_rst_n = 1'b0;
      req_valid  = 1'b0;
      req_wr     = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_be     = 4'd0;
      req_cs2    = 1'b0;
      rsp_ready  = 1'b0;
      dbi_ack    = 1'b0;
      dbi_dout   = 32'd0;
      tick();
      tick();
      pcie_rst_n = 1'b1;
      tick();

      // reset state
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_dbi_cs", {31'd0, dbi_cs}, 32'd0);
      chk("rst_dbi_addr", dbi_addr, 32'd0);
      chk("rst_dbi_din", dbi_din, 32'd0);
      chk("rst_dbi_wr", {28'd0, dbi_wr}, 32'd0);
      chk("rst_cs2", {31'd0, dbi_cs2_exp}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

      // write, ack 3 cycles after cs rises
      exp_q.push_back(32'd0);
      send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
      chk("wr_cs", {31'd0, dbi_cs}, 32'd1);
      chk("wr_dbi_wr", {28'd0, dbi_wr}, 32'hF);
      chk("wr_addr", dbi_addr, 32'h0000_0010);
      chk("wr_din", dbi_din, 32'hDEAD_BEEF);
      chk("wr_cs2", {31'd0, dbi_cs2_exp}, 32'd0);
      run_access(3, 32'h1111_2222, cs_n, lat);
      chk("wr_cs_len", cs_n, 32'd4);
      chk("wr_gap", lat, GAP_CYC);
      take_rsp("wr", 1'b0, 8'd0);

      // read in shadow space, ack on first cs cycle
      exp_q.push_back(32'h1234_10EC);
      send(1'b0, 32'h0000_0000, 32'h7777_7777, 4'hF, 1'b1);
      chk("rd_dbi_wr", {28'd0, dbi_wr}, 32'd0);
      chk("rd_addr", dbi_addr, 32'd0);
      chk("rd_cs2", {31'd0, dbi_cs2_exp}, 32'd1);
      run_access(0, 32'h1234_10EC, cs_n, lat);
      chk("rd_cs_len", cs_n, 32'd1);
      chk("rd_gap", lat, GAP_CYC);
      take_rsp("rd", 1'b0, 8'd0);

      // write with no byte enables: no bus access, response at T+1
      exp_q.push_back(32'd0);
      send(1'b1, 32'h0000_0020, 32'h5555_AAAA, 4'h0, 1'b0);
      chk("be0_cs", {31'd0, dbi_cs}, 32'd0);
      chk("be0_rsp_t1", {31'd0, rsp_valid}, 32'd1);
      take_rsp("be0", 1'b0, 8'd0);

      // response backpressure with a pending request and a stray ack
      exp_q.push_back(32'hCAFE_0001);
      send(1'b0, 32'h0000_0030, 32'd0, 4'h0, 1'b0);
      run_access(2, 32'hCAFE_0001, cs_n, lat);
      chk("bp_cs_len", cs_n, 32'd3);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 32'h0000_0040;
      req_be    = 4'h3;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         dbi_ack  = (i == 4);
         dbi_dout = 32'hBEEF_0000;
         tick();
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0001 || rsp_err !== 1'b0 ||
             req_ready !== 1'b0 || dbi_cs !== 1'b0 || err_cnt !== 8'd0)
            bad++;
      end
      dbi_ack   = 1'b0;
      req_valid = 1'b0;
      chk("bp_hold_bad_cycles", bad, 32'd0);
      take_rsp("bp", 1'b0, 8'd0);
      tick();
      tick();
      chk("bp_no_second_cs", {31'd0, dbi_cs}, 32'd0);

      // ack on the last allowed cs cycle wins over the timeout
      exp_q.push_back(32'h0BAD_F00D);
      send(1'b0, 32'h0000_0050, 32'd0, 4'hF, 1'b0);
      run_access(TIMEOUT - 1, 32'h0BAD_F00D, cs_n, lat);
      chk("edge_cs_len", cs_n, TIMEOUT);
      take_rsp("edge", 1'b0, 8'd0);

      // timeout
      exp_q.push_back(32'd0);
      send(1'b0, 32'h0000_0060, 32'd0, 4'hF, 1'b0);
      run_access(-1, 32'd0, cs_n, lat);
      chk("to_cs_len", cs_n, TIMEOUT);
      chk("to_gap", lat, GAP_CYC);
      take_rsp("to", 1'b1, 8'd1);

      // 299 more timeouts: counter climbs then saturates at 255
      for (int i = 2; i <= 300; i++) begin
         exp_q.push_back(32'd0);
         send(1'b0, 32'h0000_0070, 32'd0, 4'hF, 1'b0);
         run_access(-1, 32'd0, cs_n, lat);
         take_rsp("to_rep", 1'b1, (i > 255) ? 8'd255 : 8'(i));
      end
      chk("to_sat", {24'd0, err_cnt}, 32'd255);

      // reset in the middle of an access
      send(1'b0, 32'h0000_0080, 32'd0, 4'hF, 1'b0);
      tick();
      tick();
      tick();
      chk("mid_cs_up", {31'd0, dbi_cs}, 32'd1);
      pcie_rst_n = 1'b0;
      #1;
      chk("mid_cs_async", {31'd0, dbi_cs}, 32'd0);
      chk("mid_errcnt_clr", {24'd0, err_cnt}, 32'd0);
      tick();
      tick();
      pcie_rst_n = 1'b1;
      tick();
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("mid_ready", {31'd0, req_ready}, 32'd1);
      chk("mid_cs_low", {31'd0, dbi_cs}, 32'd0);

      // next command after reset completes normally
      exp_q.push_back(32'h0000_600D);
      send(1'b0, 32'h0000_0090, 32'd0, 4'hF, 1'b0);
      run_access(1, 32'h0000_600D, cs_n, lat);
      chk("post_cs_len", cs_n, 32'd2);
      chk("post_gap", lat, GAP_CYC);
      take_rsp("post", 1'b0, 8'd0);

      chk("exp_q_empty", exp_q.size(), 32'd0);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/ep_dbi_req_ctrl.md
Name: ep_dbi_req_ctrl

Overview:
- Upstream front end for the external DBI port of the endpoint DBI init/mux stage.
- Accepts single register read/write commands on a valid/ready request channel and drives the DBI chip-select/ack handshake with a timeout.
- Returns read data plus an error flag on a valid/ready response channel.
- Commands issued before the init sequence completes receive no ack, so they time out and complete with the error flag set.

Parameters:
- TIMEOUT, 200, maximum cs-high cycles per access before abort; legal range 2..255.
- GAP_CYC, 2, cs-low cycles enforced after every access before the response is presented; legal range 1..15.

Ports:
- core_clk  in  1  PCIe core clock; all logic is on its rising edge.
- pcie_rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  32  DBI address.
- req_wdata  in  32  write data.
- req_be  in  4  write byte enables; ignored on reads.
- req_cs2  in  1  selects the cs2_exp (shadow) register space.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_err  out  1  access timed out.
- dbi_din  out  32  to ext_drp_dbi_din.
- dbi_wr  out  4  to ext_drp_dbi_wr.
- dbi_addr  out  32  to ext_drp_dbi_addr.
- dbi_cs  out  1  to ext_drp_dbi_cs.
- dbi_cs2_exp  out  1  to ext_drp_dbi_cs2_exp.
- dbi_ack  in  1  from ext_drp_lbc_dbi_ack.
- dbi_dout  in  32  from ext_drp_lbc_dbi_dout.
- err_cnt  out  8  saturating count of timeouts.

Behaviour:
- Reset values: every output is 0, except req_ready, which is 1 once out of reset because the FSM resets to IDLE.
- All outputs are registered.
- FSM states: IDLE, ISSUE, GAP, RESP.
- IDLE:
  - req_ready=1.
  - On accept at cycle T, latch addr, wdata, cs2 and wr.
  - dbi_wr is req_be for writes and 4'h0 for reads.
  - Write with req_be==0: no bus access; go directly to RESP with rsp_err=0 and rsp_rdata=0; rsp_valid at T+1.
  - Otherwise go to ISSUE; dbi_cs=1 from T+1.
- ISSUE:
  - dbi_cs held at 1 and all dbi_* outputs held stable.
  - Cycle counter cnt starts at 0 on the first cs-high cycle and increments each cycle.
  - If dbi_ack is seen in cycle T+1+k: dbi_cs=0 at T+2+k; rsp_rdata captures dbi_dout for reads (0 for writes); rsp_err=0; go to GAP.
  - If no ack and cnt==TIMEOUT-1: dbi_cs=0 next cycle (cs is high exactly TIMEOUT cycles); rsp_err=1; rsp_rdata=0; err_cnt increments, saturating at 255; go to GAP.
  - Ack and timeout in the same cycle: ack wins and the access succeeds.
- GAP:
  - dbi_cs=0 for exactly GAP_CYC cycles; dbi_ack and dbi_dout are ignored (stale acks are discarded).
  - Then go to RESP; rsp_valid=1 at T+2+k+GAP_CYC.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err held stable until rsp_ready.
  - On handshake go to IDLE; req_ready=1 next cycle.
  - Exactly one outstanding command at a time; req_ready=0 outside IDLE.
- dbi_ack while in IDLE or RESP is ignored and has no side effects.
- cnt is 8 bits wide and clears on entry to ISSUE.
- Reset mid-access: dbi_cs drops asynchronously, the in-flight command is discarded with no response, err_cnt clears, and the FSM returns to IDLE.

Test Plan:
- Write 0x0000_0010 / 0xDEAD_BEEF / be=0xF, ack 3 cycles after cs rises -> dbi_wr=0xF; cs high 4 cycles; rsp_valid 2 cycles after cs falls; rsp_err=0; rsp_rdata=0.
- Read 0x0000_0000 with dbi_dout=0x1234_10EC at ack (ack on first cs cycle) -> dbi_wr=0; cs high 1 cycle; rsp_rdata=0x1234_10EC.
- Read with no ack -> cs high exactly 200 cycles; rsp_err=1; rsp_rdata=0; err_cnt=1. Repeat 300 times -> err_cnt=255.
- Write with be=0 -> dbi_cs never rises; rsp_valid at T+1; rsp_err=0.
- rsp_ready low 10 cycles, with req_valid high and a stray dbi_ack pulse meanwhile -> response held stable; req_ready=0; no second cs; stray ack ignored.
- Ack on the 200th cs cycle -> success, rsp_err=0. Separately, assert pcie_rst_n low mid-ISSUE -> cs=0 immediately; no response; next command completes normally.
